ofifo_col: RTL and testbench
============================

OFIFO_COL -- requirements
Module: ofifo_col

Interface
REQ-001 Parameter col, default 8: number of mac columns, one FIFO lane per column.
REQ-002 Parameter psum_bw, default 16: partial-sum width per column.
REQ-003 Parameter depth, default 64: entries per lane; power of two, at least 2.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port in, input, psum_bw*col: column psums; lane i uses bits [psum_bw*(i+1)-1 : psum_bw*i].
REQ-007 Port wr, input, col: per-lane write strobe, driven by the mac row valid vector.
REQ-008 Port rd, input, 1: pop one entry from every lane.
REQ-009 Port out, output, psum_bw*col: head entry of each lane, same slicing as in.
REQ-010 Port o_valid, output, 1: every lane holds at least one entry.
REQ-011 Port o_ready, output, 1: no lane is full.
REQ-012 Port o_full, output, 1: at least one lane is full (always equals NOT o_ready).

Function
REQ-013 Each lane SHALL be an independent circular FIFO with its own write pointer and fill count, because column results arrive skewed by one cycle per column.
REQ-014 Lane i SHALL accept in slice i on a clock edge where wr[i]=1 and the lane is not full, or where wr[i]=1 and a pop occurs in the same cycle.
REQ-015 A write to a full lane with no same-cycle pop SHALL be dropped; stored data and pointers SHALL NOT change.
REQ-016 o_valid SHALL be combinational and equal the AND of all lane non-empty flags.
REQ-017 A pop SHALL occur only when rd=1 and o_valid=1; rd=1 with o_valid=0 SHALL be ignored with no state change.
REQ-018 A pop SHALL advance every lane read pointer by one.
REQ-019 out SHALL be first-word-fall-through: while o_valid=1 it shows the current heads, with zero-cycle read latency.
REQ-020 A write SHALL become visible at out no earlier than the cycle after the write edge.
REQ-021 Pointers SHALL wrap modulo depth; fill counts SHALL be clog2(depth)+1 bits wide.
REQ-022 A simultaneous write and pop on the same lane SHALL leave that lane's count unchanged.
REQ-023 When o_valid=0, out SHALL hold the raw head-slot contents; the consumer SHALL NOT sample out in that state.

Reset
REQ-024 Asserting reset SHALL immediately clear all pointers and counts, giving o_valid=0, o_ready=1, o_full=0 and out=0.
REQ-025 A reset asserted mid-transfer SHALL discard all stored entries; the first write after release lands in slot 0.
REQ-026 Storage arrays need not be reset; out SHALL read 0 after reset, either through reset-cleared storage or a masked head.

Configuration
REQ-027 When macro OFIFO_OVERFLOW_FLAG_EN is defined, the block SHALL add output o_overflow (1 bit), which sets on any dropped write (REQ-015) and is sticky until reset.
REQ-028 When OFIFO_OVERFLOW_FLAG_EN is undefined, o_overflow and its register SHALL be absent; drop behaviour is unchanged.

Structure
REQ-029 Package ofifo_pkg SHALL hold the default col, psum_bw and depth values and the pointer-width constant derived from depth.
REQ-030 One sub-module, ofifo_lane, SHALL implement a single lane with ports clk, reset, wr, in, rd, out, empty, full.
REQ-031 The top level SHALL instantiate col lanes in a generate loop and combine their flags.

Verification
REQ-032 Skewed fill: lane i receives wr[i] at cycle i with value 16'h0100+i, rd=0 -> o_valid rises one cycle after lane 7's write, and out = {16'h0107, ..., 16'h0100}.
REQ-033 Full: 64 writes to every lane, then a 65th write to lane 3 -> o_full=1 and o_ready=0 from the 64th write onward; lane 3 still reads its first 64 values in order; o_overflow=1 when the macro is enabled.
REQ-034 Full plus concurrent pop: all lanes full; rd=1 and wr=8'hFF in the same cycle -> o_full stays 1, no drop occurs, and the new data emerges after 63 further pops.
REQ-035 Illegal pop: lane 5 empty, others hold 1 entry, rd=1 -> no pointer moves and o_valid stays 0.
REQ-036 Wrap-around: 200 write/pop pairs with lane value = cycle count -> the out sequence matches input order through three pointer wraps.
REQ-037 Mid-operation reset: 10 entries buffered, reset pulsed low mid-cycle -> o_valid=0, o_ready=1 and out=0 asynchronously; a later write/read round-trip returns the new data.

Source files
------------

// File: rtl/ofifo_pkg.sv
// ofifo_pkg: shared defaults for the column output FIFO.
//   col_def      - default number of mac columns (one lane each)
//   psum_bw_def  - default partial-sum width per column
//   depth_def    - default entries per lane (power of two, >= 2)
//   ptr_w_def    - pointer width derived from depth_def
// Optional feature macro used by ofifo_col: OFIFO_OVERFLOW_FLAG_EN.
package ofifo_pkg;

    localparam int col_def     = 8;
    localparam int psum_bw_def = 16;
    localparam int depth_def   = 64;

    // Pointer width for a power-of-two depth; fill counts use one extra bit
    // so that "full" (count == depth) is representable.
    function automatic int ptr_width(input int d);
        return $clog2(d);
    endfunction

    localparam int ptr_w_def = ptr_width(depth_def);

endpackage

// File: rtl/ofifo_lane.sv
// ofifo_lane: one independent circular FIFO lane of the column output FIFO.
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - asynchronous active-low reset
//   wr     - write strobe for this lane
//   in     - data to write
//   rd     - qualified pop (caller guarantees the lane is non-empty)
//   out    - head entry, first-word-fall-through
//   empty  - lane holds no entries
//   full   - lane holds depth entries
module ofifo_lane
    import ofifo_pkg::*;
#(
    parameter int psum_bw = psum_bw_def,
    parameter int depth   = depth_def
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic [psum_bw-1:0] in,
    input  logic               rd,
    output logic [psum_bw-1:0] out,
    output logic               empty,
    output logic               full
);

    localparam int ptr_w = ptr_width(depth);
    localparam int cnt_w = ptr_w + 1;

    logic [psum_bw-1:0] mem [depth];
    logic [ptr_w-1:0]   wr_ptr;
    logic [ptr_w-1:0]   rd_ptr;
    logic [cnt_w-1:0]   count;
    logic               push;

    assign full  = (count == cnt_w'(depth));
    assign empty = (count == '0);

    // A full lane still accepts a write when the same edge pops: the write
    // slot equals the head slot, which is read out combinationally before
    // the edge and vacated by the pointer advance.
    assign push = wr & (~full | rd);

    // Head is read straight from storage, giving zero-cycle read latency.
    assign out = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: storage is cleared on reset so out reads 0 afterwards
            // without a masking mux that would hide the raw head slot.
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= in;
                wr_ptr      <= wr_ptr + ptr_w'(1);  // wraps modulo depth
            end
            if (rd) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
            end
            case ({push, rd})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ofifo_col.sv
// ofifo_col: per-column output FIFO for a mac array. Each column has its own
// lane because column results arrive skewed by one cycle per column; a pop
// drains one entry from every lane at once.
// Ports:
//   clk        - clock
//   reset      - asynchronous active-low reset
//   in         - column psums, lane i in [psum_bw*(i+1)-1 : psum_bw*i]
//   wr         - per-lane write strobe (mac row valid vector)
//   rd         - pop one entry from every lane (ignored unless o_valid)
//   out        - head entry of each lane, same slicing as in
//   o_valid    - every lane holds at least one entry
//   o_ready    - no lane is full
//   o_full     - at least one lane is full
//   o_overflow - sticky dropped-write flag, present only when
//                OFIFO_OVERFLOW_FLAG_EN is defined
module ofifo_col
    import ofifo_pkg::*;
#(
    parameter int col     = col_def,
    parameter int psum_bw = psum_bw_def,
    parameter int depth   = depth_def
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_ready,
    output logic                   o_full
`ifdef OFIFO_OVERFLOW_FLAG_EN
   ,output logic                   o_overflow
`endif
);

    logic [col-1:0] empty;
    logic [col-1:0] full;
    logic           pop;

    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;

    for (genvar i = 0; i < col; i++) begin : g_lane
        ofifo_lane #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[i]),
            .in    (in[psum_bw*i +: psum_bw]),
            .rd    (pop),
            .out   (out[psum_bw*i +: psum_bw]),
            .empty (empty[i]),
            .full  (full[i])
        );
    end

`ifdef OFIFO_OVERFLOW_FLAG_EN
    logic drop;

    // A write is dropped only when its lane is full and no pop frees a slot.
    assign drop = |(wr & full & {col{~pop}});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ofifo_col.sv
// tb_ofifo_col: self-checking bench for ofifo_col. A queue-per-lane model
// predicts flags and heads; directed scenarios plus random traffic drive it.
module tb_ofifo_col;

    localparam int col_n     = 8;
    localparam int psum_bw_n = 16;
    localparam int depth_n   = 64;
    localparam int w_n       = col_n * psum_bw_n;

    logic               clk = 1'b0;
    logic               reset;
    logic [w_n-1:0]     in_bus;
    logic [col_n-1:0]   wr;
    logic               rd;
    logic [w_n-1:0]     out_bus;
    logic               o_valid;
    logic               o_ready;
    logic               o_full;
`ifdef OFIFO_OVERFLOW_FLAG_EN
    logic               o_overflow;
`endif

    always #5 clk = ~clk;

    ofifo_col #(
        .col     (col_n),
        .psum_bw (psum_bw_n),
        .depth   (depth_n)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in_bus),
        .wr         (wr),
        .rd         (rd),
        .out        (out_bus),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_full     (o_full)
`ifdef OFIFO_OVERFLOW_FLAG_EN
       ,.o_overflow (o_overflow)
`endif
    );

    // Reference model: one queue per lane plus a sticky drop flag.
    logic [psum_bw_n-1:0] q [col_n][$];
    bit                   ov_m;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [w_n-1:0] obs, input logic [w_n-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_valid();
        for (int i = 0; i < col_n; i++) if (q[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_full();
        for (int i = 0; i < col_n; i++) if (q[i].size() == depth_n) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [w_n-1:0] rand_bus();
        logic [w_n-1:0] v;
        for (int i = 0; i < col_n; i++) v[psum_bw_n*i +: psum_bw_n] = psum_bw_n'($urandom);
        return v;
    endfunction

    function automatic logic [w_n-1:0] same_bus(input int val);
        logic [w_n-1:0] v;
        for (int i = 0; i < col_n; i++) v[psum_bw_n*i +: psum_bw_n] = psum_bw_n'(val);
        return v;
    endfunction

    task automatic check_state(input string tag);
        logic [w_n-1:0] exp;
        bit v;
        v = model_valid();
        check({tag, " o_valid"}, w_n'(o_valid), w_n'(v));
        check({tag, " o_full"},  w_n'(o_full),  w_n'(model_full()));
        check({tag, " o_ready"}, w_n'(o_ready), w_n'(!model_full()));
`ifdef OFIFO_OVERFLOW_FLAG_EN
        check({tag, " o_overflow"}, w_n'(o_overflow), w_n'(ov_m));
`endif
        if (v) begin
            exp = '0;
            for (int i = 0; i < col_n; i++) exp[psum_bw_n*i +: psum_bw_n] = q[i][0];
            check({tag, " out"}, out_bus, exp);
        end
    endtask

    // One clock: check outputs mid-low phase, drive inputs, advance the model.
    task automatic step(input string tag, input logic [col_n-1:0] w, input logic r,
                        input logic [w_n-1:0] d);
        bit pop_m;
        bit acc [col_n];
        @(negedge clk);
        check_state(tag);
        wr     = w;
        rd     = r;
        in_bus = d;
        @(posedge clk);
        pop_m = r && model_valid();
        for (int i = 0; i < col_n; i++) begin
            acc[i] = w[i] && ((q[i].size() < depth_n) || pop_m);
            if (w[i] && !acc[i]) ov_m = 1'b1;
        end
        for (int i = 0; i < col_n; i++) begin
            if (pop_m) void'(q[i].pop_front());
            if (acc[i]) q[i].push_back(d[psum_bw_n*i +: psum_bw_n]);
        end
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k <= depth_n; k++) step(tag, '0, 1'b1, '0);
        step(tag, '0, 1'b0, '0);
    endtask

    // Reset pulsed low in the middle of a clock phase; outputs must clear at once.
    task automatic do_reset(input string tag);
        @(negedge clk);
        wr = '0;
        rd = 1'b0;
        #2 reset = 1'b0;
        #1;
        check({tag, " rst o_valid"}, w_n'(o_valid), w_n'(0));
        check({tag, " rst o_ready"}, w_n'(o_ready), w_n'(1));
        check({tag, " rst o_full"},  w_n'(o_full),  w_n'(0));
        check({tag, " rst out"},     out_bus,       '0);
`ifdef OFIFO_OVERFLOW_FLAG_EN
        check({tag, " rst o_overflow"}, w_n'(o_overflow), w_n'(0));
`endif
        for (int i = 0; i < col_n; i++) q[i].delete();
        ov_m = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [w_n-1:0] skew_exp;
        logic [w_n-1:0] d;

        reset  = 1'b0;
        wr     = '0;
        rd     = 1'b0;
        in_bus = '0;
        ov_m   = 1'b0;
        #1;
        check("init o_valid", w_n'(o_valid), w_n'(0));
        check("init o_ready", w_n'(o_ready), w_n'(1));
        check("init out",     out_bus,       '0);
        @(negedge clk);
        reset = 1'b1;

        // Skewed fill: lane i written at cycle i with 0x0100+i.
        skew_exp = '0;
        for (int c = 0; c < col_n; c++) begin
            d = '0;
            d[psum_bw_n*c +: psum_bw_n] = psum_bw_n'(16'h0100 + c);
            skew_exp[psum_bw_n*c +: psum_bw_n] = psum_bw_n'(16'h0100 + c);
            step("skew", col_n'(1) << c, 1'b0, d);
        end
        #1;
        check("skew valid", w_n'(o_valid), w_n'(1));
        check("skew out",   out_bus,       skew_exp);
        drain("skew drain");

        // Full, then a dropped 65th write to lane 3; lane 3 drains in order.
        do_reset("full");
        for (int k = 0; k < depth_n; k++) step("full wr", '1, 1'b0, rand_bus());
        #1;
        check("full o_full",  w_n'(o_full),  w_n'(1));
        check("full o_ready", w_n'(o_ready), w_n'(0));
        step("full drop", col_n'(8'h08), 1'b0, rand_bus());
        drain("full drain");

        // Full plus concurrent pop: write accepted, new data behind 63 pops.
        do_reset("fullpop");
        for (int k = 0; k < depth_n; k++) step("fullpop wr", '1, 1'b0, rand_bus());
        step("fullpop both", '1, 1'b1, same_bus(16'hBEEF));
        #1;
        check("fullpop o_full", w_n'(o_full), w_n'(1));
        for (int k = 0; k < depth_n - 1; k++) step("fullpop rd", '0, 1'b1, '0);
        #1;
        check("fullpop new", out_bus, same_bus(16'hBEEF));
        drain("fullpop drain");

        // Illegal pop: lane 5 empty, rd ignored, heads preserved.
        do_reset("illpop");
        step("illpop wr", col_n'(8'hDF), 1'b0, rand_bus());
        step("illpop rd", '0, 1'b1, '0);
        step("illpop wr5", col_n'(8'h20), 1'b0, rand_bus());
        drain("illpop drain");

        // Wrap-around: 200 write/pop pairs with value = cycle count.
        do_reset("wrap");
        step("wrap prime", '1, 1'b0, same_bus(0));
        for (int c = 1; c <= 200; c++) step("wrap", '1, 1'b1, same_bus(c));
        drain("wrap drain");

        // Random traffic.
        for (int k = 0; k < 400; k++)
            step("rand", col_n'($urandom), 1'($urandom_range(0, 2) == 0), rand_bus());
        drain("rand drain");

        // Mid-operation reset with 10 entries buffered, then a round trip.
        for (int k = 0; k < 10; k++) step("mid wr", '1, 1'b0, rand_bus());
        do_reset("mid");
        step("mid rt wr", '1, 1'b0, same_bus(16'h5A5A));
        #1;
        check("mid rt out", out_bus, same_bus(16'h5A5A));
        step("mid rt rd", '0, 1'b1, '0);
        step("mid rt idle", '0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
